// File: rtl/set_host_pkg.sv
// -----------------------------------------------------------------------------
// set_host_pkg
// Shared definitions for the SET host controller and its job queue.
//   state_t      : host sequencing states
//   job_t        : one queued job, {central[15:0], radius[7:0]}
//   TIMEOUT_CODE : candidate value reported when the engine never answers
// -----------------------------------------------------------------------------
package set_host_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE,
      GAP_WAIT
   } state_t;

   typedef struct packed {
      logic [15:0] central;
      logic [7:0]  radius;
   } job_t;

   localparam logic [7:0] TIMEOUT_CODE = 8'hFF;

endpackage

// File: rtl/set_job_fifo.sv
// -----------------------------------------------------------------------------
// set_job_fifo
// Circular job buffer of FIFO_DEPTH entries (power of two). The head entry is
// presented combinationally on pop_data so the host can latch it on the same
// edge that pops it.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (pointers/count only)
//   push        : write push_data when not full (ignored when full)
//   push_data   : job record to enqueue
//   pop         : drop head entry when not empty
//   pop_data    : current head entry
//   full, empty : occupancy flags
// -----------------------------------------------------------------------------
module set_job_fifo
   import set_host_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  job_t push_data,
   input  logic pop,
   output job_t pop_data,
   output logic full,
   output logic empty
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   job_t          mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full     = (count == (AW+1)'(FIFO_DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // Depth is a power of two, so pointers wrap naturally at their width.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/set_host.sv
// -----------------------------------------------------------------------------
// set_host
// Queues SET jobs, issues them one at a time to the SET engine, waits for the
// engine's answer (or aborts after TIMEOUT cycles) and holds the result for a
// downstream valid/ready handshake.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   job_valid/job_ready        : upstream job handshake
//   job_central, job_radius    : job payload
//   set_en                     : one-cycle engine start pulse
//   set_central, set_radius    : payload of the job in flight (held)
//   set_busy, set_valid        : engine status / result strobe
//   set_candidate              : engine result
//   res_valid/res_ready        : downstream result handshake
//   res_candidate, res_err     : result value, timeout flag
//   jobs_done                  : completed-result counter (wraps)
// -----------------------------------------------------------------------------
module set_host
   import set_host_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 64,
   parameter int GAP        = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        job_valid,
   output logic        job_ready,
   input  logic [15:0] job_central,
   input  logic [7:0]  job_radius,
   output logic        set_en,
   output logic [15:0] set_central,
   output logic [7:0]  set_radius,
   input  logic        set_busy,
   input  logic        set_valid,
   input  logic [7:0]  set_candidate,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [7:0]  res_candidate,
   output logic        res_err,
   output logic [15:0] jobs_done
);

   localparam int TW       = $clog2(TIMEOUT + 1);
   localparam int GW       = (GAP > 1) ? $clog2(GAP + 1) : 1;
   localparam int TO_LAST  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

   state_t        state;
   state_t        next_state;
   job_t          head_job;
   job_t          issue_job;
   logic          fifo_full;
   logic          fifo_empty;
   logic          pop;
   logic [TW-1:0] tcnt;
   logic [GW-1:0] gcnt;
   logic          wait_exit;

   set_job_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (job_valid),
      .push_data ({job_central, job_radius}),
      .pop       (pop),
      .pop_data  (head_job),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign job_ready   = !fifo_full;
   assign set_central = issue_job.central;
   assign set_radius  = issue_job.radius;

   always_comb begin
      next_state = state;
      pop        = 1'b0;
      set_en     = 1'b0;
      wait_exit  = 1'b0;
      case (state)
         IDLE: begin
            // A pending result blocks the next issue (downstream backpressure).
            if (!fifo_empty && !res_valid && !set_busy) begin
               next_state = ISSUE;
               pop        = 1'b1;
            end
         end
         ISSUE: begin
            set_en     = 1'b1;
            next_state = WAIT;
         end
         WAIT: begin
            // A valid arriving on the last allowed cycle wins over the abort.
            if (set_valid || (tcnt == TW'(TO_LAST))) begin
               wait_exit  = 1'b1;
               next_state = DONE;
            end
         end
         DONE: begin
            next_state = GAP_WAIT;
         end
         GAP_WAIT: begin
            if (gcnt >= GW'(GAP_LAST)) next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         issue_job     <= '0;
         tcnt          <= '0;
         gcnt          <= '0;
         res_valid     <= 1'b0;
         res_candidate <= '0;
         res_err       <= 1'b0;
         jobs_done     <= '0;
      end else begin
         state <= next_state;

         // Issue register stays put until the next job is popped, which
         // keeps the engine inputs stable through WAIT and DONE.
         if (pop) issue_job <= head_job;

         if (state == WAIT) tcnt <= tcnt + 1'b1;
         else               tcnt <= '0;

         if (state == GAP_WAIT) gcnt <= gcnt + 1'b1;
         else                   gcnt <= '0;

         // res_valid is low throughout WAIT, so loading here is invisible
         // downstream until DONE raises res_valid.
         if (wait_exit) begin
            res_candidate <= set_valid ? set_candidate : TIMEOUT_CODE;
            res_err       <= !set_valid;
         end

         if (state == DONE) begin
            res_valid <= 1'b1;
            jobs_done <= jobs_done + 1'b1;
         end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/set_host.md
SET_HOST -- requirements
Module: set_host

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, job-queue entries (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT, default 64, max cycles from set_en to set_valid before abort.
REQ-003 SHALL have parameter GAP, default 1, idle cycles after set_valid before next issue.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 job_valid  input  1  upstream job offered.
REQ-007 job_ready  output  1  queue not full; job accepted when job_valid&&job_ready.
REQ-008 job_central  input  16  {x1,y1,x2,y2} nibbles.
REQ-009 job_radius  input  8  {r1,r2} nibbles.
REQ-010 set_en  output  1  one-cycle start pulse to SET engine.
REQ-011 set_central  output  16  held job centrals.
REQ-012 set_radius  output  8  held job radii.
REQ-013 set_busy  input  1  SET engine busy.
REQ-014 set_valid  input  1  SET result valid.
REQ-015 set_candidate  input  8  SET intersection count.
REQ-016 res_valid  output  1  result held for downstream.
REQ-017 res_ready  input  1  downstream accepts; handshake completes on res_valid&&res_ready.
REQ-018 res_candidate  output  8  captured count (8'hFF on timeout).
REQ-019 res_err  output  1  result produced by timeout.
REQ-020 jobs_done  output  16  completed-result counter.

Function
REQ-021 Job queue SHALL be a FIFO_DEPTH circular buffer of {central,radius}; pointers wrap modulo FIFO_DEPTH; job_ready=0 when full.
REQ-022 Push and pop in same cycle when full SHALL NOT be accepted (job_ready depends only on full); push+pop when non-full SHALL leave count unchanged.
REQ-023 FSM states: IDLE, ISSUE, WAIT, DONE, GAP_WAIT.
REQ-024 IDLE->ISSUE when queue non-empty, res_valid=0 and set_busy=0; head job popped into issue register at transition.
REQ-025 ISSUE SHALL last exactly one cycle with set_en=1; ->WAIT.
REQ-026 set_central/set_radius SHALL be driven from issue register and held stable from ISSUE until exit of DONE (engine reads radius combinationally during computation).
REQ-027 WAIT: on set_valid=1, capture set_candidate, res_err=0 ->DONE; timeout counter counts cycles in WAIT, at TIMEOUT with no set_valid -> capture 8'hFF, res_err=1 ->DONE.
REQ-028 set_valid and timeout expiring in same cycle SHALL be treated as valid (res_err=0).
REQ-029 DONE: assert res_valid (registered), increment jobs_done (wraps 16'hFFFF->0) ->GAP_WAIT.
REQ-030 GAP_WAIT SHALL last GAP cycles, then ->IDLE; no issue while res_valid=1 (backpressure).
REQ-031 res_valid/res_candidate/res_err SHALL stay stable until res_ready handshake; then res_valid=0 next cycle.
REQ-032 set_valid outside WAIT SHALL be ignored; set_en SHALL never assert while set_busy=1.
REQ-033 Job with central 16'h0000 SHALL be issued normally; it completes via valid or timeout.
REQ-034 Issue latency: job pushed into empty queue while IDLE SHALL produce set_en two cycles after acceptance edge.

Reset
REQ-035 On rst_n=0, immediately: FSM=IDLE, queue empty, pointers 0, set_en=0, set_central=0, set_radius=0, res_valid=0, res_candidate=0, res_err=0, jobs_done=0, job_ready=1.
REQ-036 Reset mid-job SHALL discard queued and in-flight jobs; no result produced for them.

Structure
REQ-037 Shared package SHALL hold FSM state enum, job record type {central[15:0],radius[7:0]}, and constant TIMEOUT_CODE=8'hFF.
REQ-038 Job queue SHALL be a separate sub-module set_job_fifo; FSM, timeout counter and result register in set_host.

Verification
REQ-039 Push one job central 16'h4466 radius 8'h33; engine model returns valid with candidate 8'd12 five cycles after set_en -> set_en single pulse, res_candidate=12, res_err=0, jobs_done=1.
REQ-040 Push 5 jobs back-to-back with FIFO_DEPTH=4, engine stalled -> job_ready=0 after 4th accept (5th held until first pop), all 5 results in push order.
REQ-041 Engine never asserts valid -> res_valid after TIMEOUT=64 WAIT cycles with res_candidate=8'hFF, res_err=1.
REQ-042 Hold res_ready=0 for 20 cycles with 2 jobs queued -> no second set_en until handshake, first result stable throughout.
REQ-043 Assert rst_n=0 in WAIT with 3 jobs queued -> all outputs reset values same cycle, no res_valid after release, jobs_done=0.
REQ-044 set_valid coincident with timeout expiry cycle -> res_err=0, res_candidate=set_candidate.
